// File: rtl/hp_fir_serial_if.sv
// ---------------------------------------------------------------------------
// hp_fir_serial_if -- valid/ready stream of 16-bit signed samples.
//
// Signals:
//   data   signed sample, meaningful while valid=1
//   valid  producer has a sample on data
//   ready  consumer can take the sample this cycle
//
// Modports:
//   master  producer side (drives data/valid, observes ready)
//   slave   consumer side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface hp_fir_serial_if;
  logic signed [15:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/hp_fir_serial.sv
// ---------------------------------------------------------------------------
// hp_fir_serial -- streaming high-pass FIR with one time-multiplexed MAC.
//
// Each accepted sample is pushed into a TAPS-deep delay line. The filter then
// spends TAPS cycles accumulating COEF[k]*x[k], one tap per cycle. The sum is
// arithmetically shifted right by SHIFT, saturated to 16 bits and held on the
// output stream until downstream takes it. One sample per TAPS+2 cycles when
// the output is never stalled.
//
// Parameters:
//   TAPS   number of taps (2..16)
//   COEF   signed 8-bit coefficients, tap 0 in the LSBs
//   SHIFT  arithmetic right shift applied before saturation (0..15)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   in_if   input sample stream (slave): data, valid, ready
//   out_if  filtered sample stream (master): data, valid, ready
// ---------------------------------------------------------------------------
module hp_fir_serial #(
  parameter int              TAPS  = 4,
  // h0..h3 = 1, -3, 3, -1 (two's complement bytes, h3 in the MSBs)
  parameter logic [TAPS*8-1:0] COEF = {8'hFF, 8'h03, 8'hFD, 8'h01},
  parameter int              SHIFT = 3
) (
  input  logic            clk,
  input  logic            rst,
  hp_fir_serial_if.slave  in_if,
  hp_fir_serial_if.master out_if
);

  localparam int CW = $clog2(TAPS);
  // Wide enough that TAPS full-scale products can never overflow.
  localparam int AW = 16 + 8 + CW;

  localparam logic [CW-1:0]        LAST_TAP = CW'(TAPS - 1);
  localparam logic signed [AW-1:0] SAT_HI   = AW'(32767);
  localparam logic signed [AW-1:0] SAT_LO   = AW'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                state_q, state_d;
  logic signed [15:0]    x_q [TAPS];
  logic signed [15:0]    x_d [TAPS];
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [15:0]    out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  in_ready;
  logic signed [7:0]     coef_sel;
  logic signed [15:0]    x_sel;
  logic signed [23:0]    prod;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  acc_shr;
  logic signed [15:0]    sat;

  // Held low during reset even though the state register already says IDLE.
  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign in_if.ready  = in_ready;
  assign out_if.data  = out_data_q;
  assign out_if.valid = out_valid_q;

  // Serial MAC datapath: the tap selected by cnt_q is added this cycle.
  always_comb begin
    coef_sel = COEF[{cnt_q, 3'b000} +: 8];
    x_sel    = x_q[cnt_q];
    prod     = coef_sel * x_sel;
    acc_sum  = acc_q + {{CW{prod[23]}}, prod};
    // >>> on a signed operand floors toward minus infinity.
    acc_shr  = acc_sum >>> SHIFT;
    if (acc_shr > SAT_HI) begin
      sat = 16'sh7FFF;
    end else if (acc_shr < SAT_LO) begin
      sat = 16'sh8000;
    end else begin
      sat = acc_shr[15:0];
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_if.valid && in_ready) begin
          x_d[0] = in_if.data;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_TAP) begin
          // The output register takes the final sum on the way into OUT.
          out_data_d  = sat;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_if.ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the delay line is reset so a pulse on rst also flushes filter
      // history; without it the first outputs after reset would be stale.
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_hp_fir_serial.sv
// ---------------------------------------------------------------------------
// tb_hp_fir_serial -- self-checking bench for hp_fir_serial.
//
// Two instances share the same stimulus: dut0 with the default SHIFT=3 and
// dut1 with SHIFT=0 (saturates readily). A behavioural model keeps the
// accepted-sample history as a plain array and computes each expected output
// as floor(sum h[k]*x[n-k] / 2^SHIFT) clamped to 16 bits. A negedge monitor
// compares every handshaken output, the accept-to-valid latency and output
// stability during stalls. Directed sequences additionally pin literal values.
// ---------------------------------------------------------------------------
module tb_hp_fir_serial;
  localparam int TAPS = 4;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               out_ready;
  logic               rand_rdy;
  logic               rdy_force;

  hp_fir_serial_if i0 ();
  hp_fir_serial_if o0 ();
  hp_fir_serial_if i1 ();
  hp_fir_serial_if o1 ();

  assign i0.data  = in_data;
  assign i0.valid = in_valid;
  assign i1.data  = in_data;
  assign i1.valid = in_valid;
  assign o0.ready = out_ready;
  assign o1.ready = out_ready;

  hp_fir_serial dut0 (.clk(clk), .rst(rst), .in_if(i0), .out_if(o0));
  hp_fir_serial #(.SHIFT(0)) dut1 (.clk(clk), .rst(rst), .in_if(i1), .out_if(o1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  int h_ref [TAPS] = '{1, -3, 3, -1};
  int hist  [TAPS];
  int exp0_q[$];
  int exp1_q[$];
  int due_q [$];
  int obs0  [$];
  int obs1  [$];
  int last_hs_edge  = 0;
  int last_acc_edge = 0;
  int acc_cnt       = 0;
  logic               prev_valid = 1'b0;
  logic               prev_ready = 1'b0;
  logic signed [15:0] prev_data  = '0;

  always @(posedge clk) edges++;

  // Downstream ready: random in the soak phase, forced otherwise.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int model_out(input int sh);
    int acc = 0;
    for (int k = 0; k < TAPS; k++) acc += h_ref[k] * hist[k];
    acc = acc >>> sh;
    if (acc > 32767)  return 32767;
    if (acc < -32768) return -32768;
    return acc;
  endfunction

  // Monitor: signals are stable at negedge and describe the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      foreach (hist[k]) hist[k] = 0;
      exp0_q.delete();
      exp1_q.delete();
      due_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (o0.valid && !prev_valid) begin
        if (due_q.size() == 0) fail_now("latency: out_valid rose with no pending input");
        else check("latency_edge", edges, due_q.pop_front());
      end
      if (o0.valid && prev_valid && !prev_ready) check("stall_hold", o0.data, prev_data);
      if (o0.valid && out_ready) begin
        last_hs_edge = edges + 1;
        obs0.push_back(int'(o0.data));
        if (exp0_q.size() == 0) fail_now("out0: unexpected output");
        else check("out0", o0.data, exp0_q.pop_front());
      end
      if (o1.valid && out_ready) begin
        obs1.push_back(int'(o1.data));
        if (exp1_q.size() == 0) fail_now("out1: unexpected output");
        else check("out1", o1.data, exp1_q.pop_front());
      end
      if (in_valid && i0.ready) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(in_data);
        exp0_q.push_back(model_out(3));
        exp1_q.push_back(model_out(0));
        due_q.push_back(edges + 1 + TAPS);
        last_acc_edge = edges + 1;
        acc_cnt++;
      end
      prev_valid = o0.valid;
      prev_ready = out_ready;
      prev_data  = o0.data;
    end
  end

  task automatic send(input int x);
    int w = 0;
    in_data  = 16'(x);
    in_valid = 1'b1;
    @(negedge clk);
    while (!i0.ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_now("send_timeout");
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0_q.size() != 0 || o0.valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", i0.ready, 0);
    check("rst_out_valid", o0.valid, 0);
    check("rst_out_data", o0.data, 0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("idle_in_ready", i0.ready, 1);
  endtask

  task automatic check_seq(input string name, input int e[$], input int g[$]);
    check($sformatf("%s_count", name), g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s[%0d]", name, i), g[i], e[i]);
  endtask

  initial begin
    int e[$];
    int n;
    int saved;
    int v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);
    #2;

    // Impulse response
    do_reset();
    obs0.delete();
    send(800);
    repeat (4) send(0);
    drain();
    e = '{100, -300, 300, -100, 0};
    check_seq("impulse", e, obs0);

    // DC rejection
    do_reset();
    obs0.delete();
    repeat (8) send(1000);
    drain();
    e = '{125, -250, 125, 0, 0, 0, 0, 0};
    check_seq("dc", e, obs0);

    // Nyquist pass-through
    do_reset();
    obs0.delete();
    for (int i = 0; i < 10; i++) send((i % 2) ? -1000 : 1000);
    drain();
    check("nyq_count", obs0.size(), 10);
    for (int i = 3; i < 10 && i < obs0.size(); i++)
      check($sformatf("nyq[%0d]", i), obs0[i], (i % 2) ? -1000 : 1000);

    // Async reset mid-MAC: out_data currently holds -1000
    send(800);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("amid_out_valid", o0.valid, 0);
    check("amid_out_data", o0.data, 0);
    check("amid_in_ready", i0.ready, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    obs0.delete();
    send(800);
    repeat (3) send(0);
    drain();
    e = '{100, -300, 300, -100};
    check_seq("post_rst_impulse", e, obs0);

    // Saturation on the SHIFT=0 instance
    do_reset();
    obs1.delete();
    for (int i = 0; i < 10; i++) send((i % 2) ? -20000 : 20000);
    drain();
    check("sat_count", obs1.size(), 10);
    for (int i = 3; i < 10 && i < obs1.size(); i++)
      check($sformatf("sat[%0d]", i), obs1[i], (i % 2) ? -32768 : 32767);

    // Floor rounding of a negative impulse
    do_reset();
    obs0.delete();
    send(-1);
    repeat (3) send(0);
    drain();
    if (obs0.size() > 0) check("floor_first", obs0[0], -1);
    else fail_now("floor_first: no output");

    // Backpressure
    rdy_force = 1'b0;
    do_reset();
    send(800);
    in_data  = 16'sd123;
    in_valid = 1'b1;
    n = 0;
    while (!o0.valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("bp_valid_timeout");
    saved = acc_cnt;
    repeat (10) begin
      @(negedge clk);
      check("bp_data", o0.data, 100);
      check("bp_valid", o0.valid, 1);
      check("bp_in_ready", i0.ready, 0);
    end
    check("bp_no_accept", acc_cnt, saved);
    @(posedge clk);
    #2;
    rdy_force = 1'b1;
    send(123);
    check("bp_accept_gap", last_acc_edge - last_hs_edge, 1);
    repeat (3) send(0);
    drain();

    // Randomized soak with random bubbles and random downstream stalls
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 1) ? 32767 : -32768;
      else v = int'($signed(16'($urandom)));
      send(v);
    end
    drain();
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hp_fir_serial.md
Name: hp_fir_serial

Overview:
- Streaming high-pass FIR that serves as the complement of the team's 2-tap low-pass smoother; it extracts edge and transient content from the same 16-bit signed sample stream.
- Uses one time-multiplexed multiplier: a serial MAC handles one tap per cycle.
- Has valid/ready handshakes on both sides, so it can sit between a sample source and downstream logic that applies backpressure.
- Output is scaled by an arithmetic right shift and saturated to 16 bits.

Parameters:
- TAPS, 4, number of filter taps (2..16).
- COEF, {8'sd-1, 8'sd3, 8'sd-3, 8'sd1} packed with tap0 in the LSBs (coefficient order h0..h3 = 1, -3, 3, -1), signed 8-bit coefficients, TAPS*8 bits wide.
- SHIFT, 3, arithmetic right shift applied to the accumulator before saturation (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  16  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  16  signed filtered sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset values (rst high, async): state=IDLE; delay line x[0..TAPS-1]=0; accumulator=0; tap counter=0; out_data=0; out_valid=0; in_ready=0 while rst is asserted.
- Accumulator width is 16+8+clog2(TAPS) bits, signed. Products and the accumulator are sign-extended, with no intermediate overflow.
- IDLE state:
  - in_ready=1.
  - On in_valid&&in_ready: x[k]<=x[k-1] for k>=1, x[0]<=in_data; acc<=0; cnt<=0; go to MAC.
  - Otherwise stay in IDLE.
- MAC state:
  - in_ready=0.
  - Each cycle: acc<=acc+COEF[cnt]*x[cnt]; cnt<=cnt+1.
  - The cycle where cnt==TAPS-1 performs the final add and goes to OUT.
  - Exactly TAPS cycles are spent in MAC.
- OUT state entry:
  - out_data<=sat16(acc>>>SHIFT), registered on the transition into OUT.
  - The shift is arithmetic (rounds toward minus infinity).
  - sat16 clamps to [-32768, 32767].
  - out_valid=1 throughout OUT.
- OUT state handshake:
  - out_data and out_valid hold stable while out_ready=0.
  - On out_ready=1: out_valid<=0 and go to IDLE.
  - in_ready=0 throughout OUT.
- Latency: input accepted at edge N produces out_valid high after edge N+TAPS. With out_ready held high, the next sample is accepted at edge N+TAPS+2, giving one sample per TAPS+2 cycles.
- Delay line:
  - Shifts only on an accepted input.
  - Stalls (out_ready low) do not shift and do not drop samples.
  - in_valid is ignored while in_ready=0; the upstream must hold in_data and in_valid.
- Warm-up: the first TAPS-1 outputs use zeros for unfilled taps. No outputs are suppressed.
- Reset mid-MAC or mid-OUT: immediate return to the reset values. Any pending output is discarded and the delay line is cleared.
- out_data retains its last value after out_valid falls. The value is meaningful only while out_valid=1.

Test Plan:
- Impulse: release rst, send 800 then four 0s with out_ready=1 -> outputs 100, -300, 300, -100, 0. Each out_valid rises exactly TAPS(4) edges after its accept.
- DC rejection: send 1000 eight times -> outputs 125, -250, 125, 0, 0, 0, 0, 0.
- Nyquist pass: send alternating +1000/-1000 ten times -> after the 4th output, steady alternation of +1000/-1000 matching the input sign.
- Saturation and rounding:
  - With SHIFT=0, alternating +20000/-20000 -> steady outputs clamp to 32767/-32768.
  - With default SHIFT, a single -1 impulse -> first output -1 (floor), not 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 and new data -> out_data stable, in_ready=0, and no input consumed. Release -> the next accept occurs one cycle after the handshake, and the filter history matches a no-stall run.
- Async reset mid-MAC: assert rst 2 cycles after accepting 800 -> out_valid=0, out_data=0, in_ready=0 immediately without a clock edge. After release, an impulse of 800 reproduces 100, -300, 300, -100 (history cleared).
